ipv4_deparser: RTL

Write-side counterpart of the IPv4/TCP header parser. It takes one header word (first 480 bits of a packet) plus per-field rewrite values from the match-action stages and merges the valid fields back into the word. When enabled, it recomputes the IPv4 header checksum. It sits at the pipeline egress, between the last action stage and the output queues, and uses a valid/ready handshake with a 2-stage stallable pipeline.

---
 rtl/ipv4_deparser.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ipv4_deparser.sv
// Egress header deparser: merges rewrite fields into the header word, with an optional IPv4 checksum refresh.
// The checksum refresh is built only when IPV4_CSUM_UPDATE_EN is defined.
module ipv4_deparser #(
  parameter int unsigned DATA_WIDTH = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pkt_data_vld_in,
  input  logic [DATA_WIDTH-1:0] pkt_data_in,
  output logic                  in_rdy,
  input  logic                  dmac_vld,
  input  logic [47:0]           dmac_data,
  input  logic                  smac_vld,
  input  logic [47:0]           smac_data,
  input  logic                  sip_vld,
  input  logic [31:0]           sip_data,
  input  logic                  dip_vld,
  input  logic [31:0]           dip_data,
  input  logic                  sport_vld,
  input  logic [15:0]           sport_data,
  input  logic                  dport_vld,
  input  logic [15:0]           dport_data,
  output logic                  pkt_data_vld_out,
  output logic [DATA_WIDTH-1:0] pkt_data_out,
  input  logic                  out_rdy,
  output logic [31:0]           rewrite_cnt
);

  localparam int unsigned DW = DATA_WIDTH;

  // Vector MSB of each field: wire bit k sits at vector bit DW-1-k.
  localparam int unsigned DMAC_MSB  = DW - 1;
  localparam int unsigned SMAC_MSB  = DW - 49;
  localparam int unsigned ETH_MSB   = DW - 97;
  localparam int unsigned IPH_MSB   = DW - 113;
  localparam int unsigned IHL_MSB   = DW - 117;
  localparam int unsigned PROTO_MSB = DW - 185;
  localparam int unsigned CSUM_MSB  = DW - 193;
  localparam int unsigned SIP_MSB   = DW - 209;
  localparam int unsigned DIP_MSB   = DW - 241;
  localparam int unsigned SPORT_MSB = DW - 273;
  localparam int unsigned DPORT_MSB = DW - 289;

  logic          advance;
  logic          in_ipv4_c;
  logic          in_tcp_c;
  logic          in_changed_c;
  logic [DW-1:0] merged_c;
  logic [DW-1:0] s2_word_c;

  logic          s1_vld;
  logic          s1_changed;
  logic [DW-1:0] s1_data;
  logic          out_changed;

  assign advance = !pkt_data_vld_out || out_rdy;
  assign in_rdy  = advance;

  // Field merge with protocol qualification of the L3/L4 fields.
  always_comb begin
    logic wr_dmac, wr_smac, wr_sip, wr_dip, wr_sport, wr_dport;
    merged_c  = pkt_data_in;
    in_ipv4_c = (pkt_data_in[ETH_MSB -: 16] == 16'h0800) && (pkt_data_in[IHL_MSB -: 4] == 4'd5);
    in_tcp_c  = in_ipv4_c && (pkt_data_in[PROTO_MSB -: 8] == 8'h06);
    wr_dmac   = pkt_data_vld_in && dmac_vld;
    wr_smac   = pkt_data_vld_in && smac_vld;
    wr_sip    = pkt_data_vld_in && sip_vld && in_ipv4_c;
    wr_dip    = pkt_data_vld_in && dip_vld && in_ipv4_c;
    wr_sport  = pkt_data_vld_in && sport_vld && in_tcp_c;
    wr_dport  = pkt_data_vld_in && dport_vld && in_tcp_c;
    if (wr_dmac)  merged_c[DMAC_MSB -: 48]  = dmac_data;
    if (wr_smac)  merged_c[SMAC_MSB -: 48]  = smac_data;
    if (wr_sip)   merged_c[SIP_MSB -: 32]   = sip_data;
    if (wr_dip)   merged_c[DIP_MSB -: 32]   = dip_data;
    if (wr_sport) merged_c[SPORT_MSB -: 16] = sport_data;
    if (wr_dport) merged_c[DPORT_MSB -: 16] = dport_data;
    in_changed_c = wr_dmac || wr_smac || wr_sip || wr_dip || wr_sport || wr_dport;
  end

`ifdef IPV4_CSUM_UPDATE_EN
  logic        s1_ipv4;
  logic [16:0] psum_c [5];
  logic [16:0] s1_psum [5];
  logic [15:0] csum_c;

  // Pairwise halfword sums of the IPv4 header; the checksum halfword counts as zero.
  always_comb begin
    logic [15:0] hi, lo;
    for (int i = 0; i < 5; i++) begin
      hi = merged_c[IPH_MSB - 32*i -: 16];
      lo = (i == 2) ? 16'h0000 : merged_c[IPH_MSB - 16 - 32*i -: 16];
      psum_c[i] = {1'b0, hi} + {1'b0, lo};
    end
  end

  // Ones' complement fold of the partial sums, then invert.
  always_comb begin
    logic [19:0] total;
    logic [16:0] fold1;
    logic [15:0] fold2;
    total = 20'(s1_psum[0]) + 20'(s1_psum[1]) + 20'(s1_psum[2])
          + 20'(s1_psum[3]) + 20'(s1_psum[4]);
    fold1 = {1'b0, total[15:0]} + 17'(total[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
    csum_c = ~fold2;
    s2_word_c = s1_data;
    if (s1_ipv4) s2_word_c[CSUM_MSB -: 16] = csum_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_ipv4 <= 1'b0;
      for (int i = 0; i < 5; i++) s1_psum[i] <= '0;
    end else if (advance && pkt_data_vld_in) begin
      s1_ipv4 <= in_ipv4_c;
      for (int i = 0; i < 5; i++) s1_psum[i] <= psum_c[i];
    end
  end
`else
  always_comb begin
    s2_word_c = s1_data;
  end
`endif

  // Stage 1: merged word and its side flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld     <= 1'b0;
      s1_changed <= 1'b0;
      s1_data    <= '0;
    end else if (advance) begin
      s1_vld <= pkt_data_vld_in;
      if (pkt_data_vld_in) begin
        s1_changed <= in_changed_c;
        s1_data    <= merged_c;
      end
    end
  end

  // Stage 2: output register, held while downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_data_vld_out <= 1'b0;
      pkt_data_out     <= '0;
      out_changed      <= 1'b0;
    end else if (advance) begin
      pkt_data_vld_out <= s1_vld;
      if (s1_vld) begin
        pkt_data_out <= s2_word_c;
        out_changed  <= s1_changed;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rewrite_cnt <= '0;
    end else if (pkt_data_vld_out && out_rdy && out_changed) begin
      rewrite_cnt <= rewrite_cnt + 32'd1;
    end
  end

endmodule
